// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for the 4-way round-robin mux arbiter: request/data lines in,
// registered grant/select/data out.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       out;

    // Requester side drives req/in and observes the arbitration result.
    modport master (
        output req,
        output in,
        input  gnt,
        input  sel,
        input  valid,
        input  out
    );

    // Arbiter side consumes req/in and produces grant and muxed data.
    modport slave (
        input  req,
        input  in,
        output gnt,
        output sel,
        output valid,
        output out
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux among four requesters.
// The owner keeps the grant while it holds req, but once it has been BUSY for
// MAX_HOLD cycles with another request pending it is handed over to the next
// requester in round-robin order. The selected data bit is registered.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_q;

    logic [3:0] owner_oh;
    logic [3:0] other_req;
    logic [2:0] idle_pick;
    logic [2:0] busy_pick;
    logic [1:0] after_owner;
    logic       release_ev;
    logic       preempt_ev;

    // Returns {found, index}: first set bit of r scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Scan from the far end so the closest index to start is written last.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // One-hot decode of the current owner, used to mask it out of the next arbitration.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_owner_oh
            assign owner_oh[gi] = (sel_q == 2'(gi));
        end
    endgenerate

    // Arbitration candidates for both the IDLE and BUSY cases.
    always_comb begin
        other_req   = bus.req & ~owner_oh;
        after_owner = sel_q + 2'd1;
        idle_pick   = rr_pick(bus.req, ptr_q);
        busy_pick   = rr_pick(other_req, after_owner);
        release_ev  = ~|(bus.req & owner_oh);
        preempt_ev  = (cnt_q == CNT_MAX) && (|other_req);
    end

    // Arbiter FSM with registered grant, select and muxed data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_pick[2]) begin
                        // IDLE-entry grants leave ptr untouched.
                        gnt_q   <= onehot(idle_pick[1:0]);
                        sel_q   <= idle_pick[1:0];
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        out_q   <= bus.in[idle_pick[1:0]];
                    end else begin
                        gnt_q <= 4'b0000;
                        out_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_ev || preempt_ev) begin
                        ptr_q <= after_owner;
                        if (busy_pick[2]) begin
                            // Direct handover, no idle cycle in between.
                            gnt_q <= onehot(busy_pick[1:0]);
                            sel_q <= busy_pick[1:0];
                            cnt_q <= '0;
                            out_q <= bus.in[busy_pick[1:0]];
                        end else begin
                            gnt_q   <= 4'b0000;
                            state_q <= IDLE;
                            out_q   <= 1'b0;
                        end
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        out_q <= bus.in[sel_q];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = |gnt_q;
    assign bus.out   = out_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- Grants at most one requester at a time and drives the mux select from the grant.
- Registers the selected data bit as the shared output.
- Enforces a maximum hold time, so a requester that holds its request cannot starve the others.

Parameters:
- MAX_HOLD, 8, maximum number of consecutive BUSY cycles an owner keeps the grant while another request is pending; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the mux; held high for the whole transfer.
- in  input  4  data bits; in[i] belongs to requester i.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  encoded index of the current owner, registered; drives the mux select.
- valid  output  1  high while any grant is active (equals |gnt).
- out  output  1  registered mux output.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high at a rising edge sets: gnt=0, sel=0, valid=0, out=0, state=IDLE, ptr=0, cnt=0.
  - Reset overrides all other events, including mid-grant; the grant drops on the next edge.
- State: IDLE, BUSY. ptr[1:0] is the highest-priority index for the next arbitration.
- Arbitration function: scan req[ptr], req[ptr+1], ... req[ptr+3], indices mod 4. The first set bit wins. Wrap-around from 3 to 0 is required.
- IDLE:
  - If req != 0 at an edge: gnt <= onehot(winner), sel <= winner, state <= BUSY, cnt <= 0.
  - Latency from req rising to gnt high is 1 cycle.
  - Otherwise stay IDLE with gnt=0.
- BUSY, owner o = sel:
  - Release: req[o]==0 at an edge.
  - Preempt: cnt==MAX_HOLD-1 and (req & ~onehot(o)) != 0.
  - On release or preempt:
    - ptr <= o+1 mod 4.
    - Arbitrate over req & ~onehot(o), starting at o+1.
    - If there is a winner: gnt/sel switch to it on this edge, with no idle cycle, cnt <= 0, stay BUSY.
    - If there is no winner: gnt <= 0, state <= IDLE.
  - Otherwise: gnt unchanged, cnt <= cnt+1, saturating at MAX_HOLD-1.
  - Owner alone with no other request keeps the grant indefinitely; cnt saturates and no preemption occurs.
- Simultaneous events:
  - Owner drops req in the same cycle others raise req: treated as release; the handover happens on that edge.
  - A preempted owner that still holds req competes again only after the other pending requesters in round-robin order.
  - A newly raised req during BUSY is only considered at the next release/preempt.
- ptr update: ptr is updated only on handover or release, to owner+1. IDLE-entry grants leave ptr unchanged. ptr=0 after reset, so when all req rise together after reset, requester 0 wins first.
- Data path:
  - out <= valid_next ? in[sel_next] : 0, registered in the same edge as gnt/sel.
  - Thereafter out <= in[sel] each cycle while BUSY, so out lags in[sel] by 1 cycle.
  - out=0 whenever gnt=0.
- Invariants, every cycle: gnt is one-hot or zero; sel == index(gnt) when valid; valid == |gnt.

Test Plan:
- Reset with req=4'b1111, then deassert rst -> next edge gnt=4'b0001, sel=0, valid=1; out follows in[0] one cycle later.
- req=4'b0100 only; hold 3 cycles, then drop -> gnt=4'b0100 one cycle after req; gnt=0 and valid=0 the edge after the drop.
- MAX_HOLD=8, req=4'b0011 held constantly -> grant alternates 0,1,0,1 with exactly 8 cycles per owner; no cycle with gnt=0.
- Owner 3 releases while req=4'b0001 -> grant wraps to 0 on the release edge; ptr=0 afterwards.
- req=4'b1000 alone for 20 cycles -> gnt stays 4'b1000 and cnt saturates at 7; raise req[1] -> handover to 1 on the next edge.
- Assert rst mid-grant (gnt=4'b0010, out=1) -> next edge gnt=0, sel=0, out=0; after rst drops, arbitration restarts with priority to requester 0.
